pkt_ingress_arb: RTL and testbench

Multi-port ingress arbiter feeding the enqueue side of `pkt_sche_v0_1`. Collects packets from `NPORT` requesters over valid/ready handshakes and grants one per cycle: urgent requesters first, round-robin within each class, with a bounded-starvation guarantee for normal traffic. Drives the scheduler's `in_enque_en` / `in_ugr_en` / `in_pkt_info` / `in_data` from a one-entry registered output stage, and honours the scheduler's `ready` as back-pressure.

---
 rtl/pkt_ingress_arb.sv | 139 +++++++++++++
 tb/tb_pkt_ingress_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_ingress_arb.sv
// Multi-port ingress arbiter: urgent-first round-robin with bounded starvation of
// normal traffic, feeding a scheduler enqueue port through a one-entry output stage.
module pkt_ingress_arb #(
  parameter int NPORT      = 4,
  parameter int DWIDTH     = 32,
  parameter int IWIDTH     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [NPORT-1:0]          req_valid,
  input  logic [NPORT-1:0]          req_urgent,
  input  logic [NPORT*IWIDTH-1:0]   req_info,
  input  logic [NPORT*DWIDTH-1:0]   req_data,
  output logic [NPORT-1:0]          req_ready,
  input  logic                      sch_ready,
  output logic                      sch_enque_en,
  output logic                      sch_ugr_en,
  output logic [IWIDTH-1:0]         sch_pkt_info,
  output logic [DWIDTH-1:0]         sch_data,
  output logic [$clog2(NPORT)-1:0]  grant_port
);

  localparam int PW = $clog2(NPORT);
  localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [PW-1:0] LAST_PORT  = PW'(NPORT - 1);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic [PW-1:0]     u_ptr_r, n_ptr_r;
  logic [7:0]        starve_r;
  logic              ugr_r;
  logic [IWIDTH-1:0] info_r;
  logic [DWIDTH-1:0] data_r;
  logic [PW-1:0]     port_r;

  logic [NPORT-1:0]  u_set_s, n_set_s;
  logic [PW:0]       u_pick_s, n_pick_s;
  logic              pop_s, can_grant_s, grant_s, sel_normal_s;
  logic [PW-1:0]     winner_s, winner_inc_s;

  // First set bit of mask searching upward from ptr with wrap; MSB flags a hit.
  function automatic logic [PW:0] rr_pick(input logic [NPORT-1:0] mask,
                                          input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          idx;
    res = {(PW+1){1'b0}};
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (mask[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  // Class selection, winner search and grant qualification.
  always_comb begin
    u_set_s      = req_valid & req_urgent;
    n_set_s      = req_valid & ~req_urgent;
    u_pick_s     = rr_pick(u_set_s, u_ptr_r);
    n_pick_s     = rr_pick(n_set_s, n_ptr_r);
    pop_s        = (state_r == FULL) && sch_ready;
    can_grant_s  = arb_en && !rst && ((state_r == EMPTY) || pop_s);
    sel_normal_s = (n_set_s != {NPORT{1'b0}}) &&
                   ((u_set_s == {NPORT{1'b0}}) || (starve_r == STARVE_LIM));
    winner_s     = sel_normal_s ? n_pick_s[PW-1:0] : u_pick_s[PW-1:0];
    grant_s      = can_grant_s && (req_valid != {NPORT{1'b0}});
    if (winner_s == LAST_PORT) begin
      winner_inc_s = {PW{1'b0}};
    end else begin
      winner_inc_s = winner_s + PW'(1);
    end
    if (grant_s) begin
      req_ready = {{(NPORT-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      req_ready = {NPORT{1'b0}};
    end
  end

  // Output stage next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY:   state_nxt_s = grant_s ? FULL : EMPTY;
      FULL:    state_nxt_s = (pop_s && !grant_s) ? EMPTY : FULL;
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State register and output stage load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
      ugr_r   <= 1'b0;
      info_r  <= {IWIDTH{1'b0}};
      data_r  <= {DWIDTH{1'b0}};
      port_r  <= {PW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        ugr_r  <= req_urgent[winner_s];
        info_r <= req_info[int'(winner_s)*IWIDTH +: IWIDTH];
        data_r <= req_data[int'(winner_s)*DWIDTH +: DWIDTH];
        port_r <= winner_s;
      end
    end
  end

  // Round-robin pointers and starvation counter; the counter only climbs while
  // a normal request is actually being passed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_ptr_r  <= {PW{1'b0}};
      n_ptr_r  <= {PW{1'b0}};
      starve_r <= 8'd0;
    end else if (grant_s) begin
      if (sel_normal_s) begin
        n_ptr_r  <= winner_inc_s;
        starve_r <= 8'd0;
      end else begin
        u_ptr_r <= winner_inc_s;
        if (n_set_s == {NPORT{1'b0}}) begin
          starve_r <= 8'd0;
        end else if (starve_r < STARVE_LIM) begin
          starve_r <= starve_r + 8'd1;
        end
      end
    end
  end

  assign sch_enque_en = (state_r == FULL);
  assign sch_ugr_en   = ugr_r;
  assign sch_pkt_info = info_r;
  assign sch_data     = data_r;
  assign grant_port   = port_r;

endmodule

// File: tb/tb_pkt_ingress_arb.sv
// Directed bench for pkt_ingress_arb: reset, streaming, round-robin, starvation,
// back-pressure and arb_en gating, each with hand-computed expectations.
module tb_pkt_ingress_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         arb_en;
  logic [3:0]   req_valid;
  logic [3:0]   req_urgent;
  logic [127:0] req_info;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         sch_ready;
  logic         sch_enque_en;
  logic         sch_ugr_en;
  logic [31:0]  sch_pkt_info;
  logic [31:0]  sch_data;
  logic [1:0]   grant_port;

  int total = 0;
  int bad   = 0;

  pkt_ingress_arb #(.NPORT(4), .DWIDTH(32), .IWIDTH(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .req_valid(req_valid), .req_urgent(req_urgent),
    .req_info(req_info), .req_data(req_data), .req_ready(req_ready),
    .sch_ready(sch_ready), .sch_enque_en(sch_enque_en), .sch_ugr_en(sch_ugr_en),
    .sch_pkt_info(sch_pkt_info), .sch_data(sch_data), .grant_port(grant_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: assert reset, check outputs with no edge, then release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_enque", {63'd0, sch_enque_en}, 64'd0);
    chk("rst_data", {32'd0, sch_data}, 64'd0);
    chk("rst_info", {32'd0, sch_pkt_info}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_port", {62'd0, grant_port}, 64'd0);
    req_valid  = 4'b0000;
    req_urgent = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    int         exp_p;
    rst        = 1'b1;
    arb_en     = 1'b1;
    req_valid  = 4'b0000;
    req_urgent = 4'b0000;
    req_info   = 128'd0;
    req_data   = 128'd0;
    sch_ready  = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming on port 2, one packet per cycle.
    req_valid = 4'b0100;
    for (int i = 0; i < 64; i++) begin
      req_data[64 +: 32] = 32'h114 + 32'(i);
      req_info[64 +: 32] = 32'h1000 + 32'(i);
      #1;
      chk("stream_ready", {60'd0, req_ready}, 64'h4);
      edge_wait();
      chk("stream_enque", {63'd0, sch_enque_en}, 64'd1);
      chk("stream_data", {32'd0, sch_data}, {32'd0, 32'h114 + 32'(i)});
      chk("stream_info", {32'd0, sch_pkt_info}, {32'd0, 32'h1000 + 32'(i)});
      chk("stream_port", {62'd0, grant_port}, 64'd2);
      chk("stream_ugr", {63'd0, sch_ugr_en}, 64'd0);
    end
    // Reset while stage is full and port 2 still requests.
    do_reset();

    // Round-robin among four normal requesters.
    for (int p = 0; p < 4; p++) req_data[p*32 +: 32] = 32'h100 + 32'(p);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_p   = i % 4;
      exp_rdy = 4'b0001 << exp_p;
      #1;
      chk("rr_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
      edge_wait();
      chk("rr_port", {62'd0, grant_port}, 64'(exp_p));
      chk("rr_data", {32'd0, sch_data}, 64'(32'h100 + exp_p));
      chk("rr_ugr", {63'd0, sch_ugr_en}, 64'd0);
    end
    // Ports 1 and 3 become urgent and alternate ahead of 0 and 2.
    req_urgent = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      exp_p   = (i % 2 == 0) ? 1 : 3;
      exp_rdy = 4'b0001 << exp_p;
      #1;
      chk("urg_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
      edge_wait();
      chk("urg_port", {62'd0, grant_port}, 64'(exp_p));
      chk("urg_ugr", {63'd0, sch_ugr_en}, 64'd1);
    end
    do_reset();

    // Starvation bound: 8 urgent grants to port 0, then one normal to port 1.
    req_valid  = 4'b0011;
    req_urgent = 4'b0001;
    for (int i = 0; i < 18; i++) begin
      exp_p   = (i % 9 == 8) ? 1 : 0;
      exp_rdy = 4'b0001 << exp_p;
      #1;
      chk("starve_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
      edge_wait();
      chk("starve_port", {62'd0, grant_port}, 64'(exp_p));
      chk("starve_ugr", {63'd0, sch_ugr_en}, (exp_p == 0) ? 64'd1 : 64'd0);
    end
    do_reset();

    // Back-pressure with the stage holding 0x114514.
    sch_ready          = 1'b0;
    req_valid          = 4'b0001;
    req_info[0 +: 32]  = 32'h114514;
    req_data[0 +: 32]  = 32'h55;
    #1;
    chk("bp_first_ready", {60'd0, req_ready}, 64'h1);
    edge_wait();
    chk("bp_first_enque", {63'd0, sch_enque_en}, 64'd1);
    req_info[0 +: 32] = 32'h2222;
    req_data[0 +: 32] = 32'h66;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_ready", {60'd0, req_ready}, 64'd0);
      edge_wait();
      chk("bp_hold_info", {32'd0, sch_pkt_info}, 64'h114514);
      chk("bp_hold_data", {32'd0, sch_data}, 64'h55);
      chk("bp_hold_enque", {63'd0, sch_enque_en}, 64'd1);
    end
    sch_ready = 1'b1;
    #1;
    chk("bp_release_ready", {60'd0, req_ready}, 64'h1);
    edge_wait();
    chk("bp_release_info", {32'd0, sch_pkt_info}, 64'h2222);
    chk("bp_release_data", {32'd0, sch_data}, 64'h66);

    // arb_en low: drain, stay empty, then resume from preserved n_ptr (=1).
    req_info[0 +: 32] = 32'h3333;
    arb_en = 1'b0;
    #1;
    chk("dis_ready", {60'd0, req_ready}, 64'd0);
    edge_wait();
    chk("dis_drain", {63'd0, sch_enque_en}, 64'd0);
    for (int p = 0; p < 4; p++) req_data[p*32 +: 32] = 32'h200 + 32'(p);
    req_valid = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("dis_idle_ready", {60'd0, req_ready}, 64'd0);
      edge_wait();
      chk("dis_idle_enque", {63'd0, sch_enque_en}, 64'd0);
    end
    arb_en = 1'b1;
    #1;
    chk("en_ready", {60'd0, req_ready}, 64'h2);
    edge_wait();
    chk("en_port", {62'd0, grant_port}, 64'd1);
    chk("en_data", {32'd0, sch_data}, 64'h201);
    chk("en_enque", {63'd0, sch_enque_en}, 64'd1);
    #1;
    chk("en_next_ready", {60'd0, req_ready}, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
